minmax_tracker: RTL and testbench



---
 rtl/minmax_tracker.sv | 203 ++++++++++++++++++++
 tb/tb_minmax_tracker.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/minmax_tracker.sv
// ---------------------------------------------------------------------------
// minmax_tracker
//
// Watches a framed stream of unsigned N-bit samples. For each frame it
// reports the minimum, the maximum and the number of samples. Results are
// handed to a consumer over a valid/ready handshake.
//
// A single compare datapath (less-than, greater-than, equal) is shared by
// every sample of a frame. One sample can be accepted per clock while
// IDLE or ACCUM.
//
// Optional feature macro: MINMAX_INDEX_EN
//    When defined, min_idx/max_idx ports and registers exist. They report
//    the 0-based position of the first occurrence of the minimum and the
//    maximum within the frame.
//
// Parameters:
//    N      sample width in bits (unsigned)
//    CNT_W  width of the sample counter and index outputs
//
// Ports:
//    clk        rising-edge clock
//    rst_n      asynchronous active-low reset
//    in_valid   sample present
//    in_ready   block accepts a sample (high in IDLE/ACCUM, low in HOLD)
//    in_data    sample value, unsigned
//    in_last    final sample of the frame, qualified by in_valid
//    out_valid  frame result available
//    out_ready  consumer accepts the result
//    min_val    frame minimum
//    max_val    frame maximum
//    count      samples in the frame, saturating at all-ones
//    ovf        count saturated during this frame
//    eq_all     out_valid and min_val == max_val
//    min_idx    index of first minimum (MINMAX_INDEX_EN only)
//    max_idx    index of first maximum (MINMAX_INDEX_EN only)
// ---------------------------------------------------------------------------
module minmax_tracker #(
   parameter int N     = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     min_val,
   output logic [N-1:0]     max_val,
   output logic [CNT_W-1:0] count,
   output logic             ovf,
   output logic             eq_all
`ifdef MINMAX_INDEX_EN
   ,
   output logic [CNT_W-1:0] min_idx,
   output logic [CNT_W-1:0] max_idx
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t           r_state;
   logic [N-1:0]     r_min;
   logic [N-1:0]     r_max;
   logic [CNT_W-1:0] r_count;
   logic             r_ovf;
   logic             r_outValid;
`ifdef MINMAX_INDEX_EN
   logic [CNT_W-1:0] r_minIdx;
   logic [CNT_W-1:0] r_maxIdx;
`endif

   logic             w_inReady;
   logic             w_accept;
   logic             w_lessThan;
   logic             w_greaterThan;
   logic             w_minMaxEqual;
   logic             w_countFull;
   logic [CNT_W-1:0] w_countInc;

   // in_ready is decoded from state only. This keeps it free of any
   // combinational path from in_valid or out_ready. HOLD back-pressures
   // the source, so no sample is lost while a result is waiting.
   assign w_inReady = (r_state != ST_HOLD);
   assign w_accept  = in_valid & w_inReady;

   // Shared compare datapath. The incoming sample is compared against the
   // running extremes. The equality term compares the two extremes with
   // each other and feeds eq_all.
   assign w_lessThan    = (in_data < r_min);
   assign w_greaterThan = (in_data > r_max);
   assign w_minMaxEqual = (r_min == r_max);

   // The counter saturates at all-ones. w_countFull marks the point where
   // a further accepted sample must hold the count and raise ovf instead.
   assign w_countFull = &r_count;
   assign w_countInc  = r_count + CNT_W'(1);

   // Control FSM and result registers, updated together.
   // IDLE  : the first accepted sample seeds min/max, count = 1, clears
   //         ovf and indices. in_last on that sample goes straight to
   //         HOLD; otherwise the FSM moves to ACCUM.
   // ACCUM : strict compares, so ties keep the earliest value and index.
   //         An index captures the count before it is incremented, which
   //         equals the 0-based position until the counter saturates.
   // HOLD  : the result is presented and held stable until out_ready.
   //         The results are kept after the handshake. The next frame's
   //         first sample overwrites them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_min      <= '0;
         r_max      <= '0;
         r_count    <= '0;
         r_ovf      <= 1'b0;
         r_outValid <= 1'b0;
`ifdef MINMAX_INDEX_EN
         r_minIdx   <= '0;
         r_maxIdx   <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_min   <= in_data;
                  r_max   <= in_data;
                  r_count <= CNT_W'(1);
                  r_ovf   <= 1'b0;
`ifdef MINMAX_INDEX_EN
                  r_minIdx <= '0;
                  r_maxIdx <= '0;
`endif
                  if (in_last) begin
                     r_state    <= ST_HOLD;
                     r_outValid <= 1'b1;
                  end else begin
                     r_state    <= ST_ACCUM;
                  end
               end
            end

            ST_ACCUM: begin
               if (w_accept) begin
                  if (w_lessThan) begin
                     r_min <= in_data;
`ifdef MINMAX_INDEX_EN
                     r_minIdx <= r_count;
`endif
                  end
                  if (w_greaterThan) begin
                     r_max <= in_data;
`ifdef MINMAX_INDEX_EN
                     r_maxIdx <= r_count;
`endif
                  end
                  if (w_countFull) begin
                     r_ovf <= 1'b1;
                  end else begin
                     r_count <= w_countInc;
                  end
                  if (in_last) begin
                     r_state    <= ST_HOLD;
                     r_outValid <= 1'b1;
                  end
               end
            end

            ST_HOLD: begin
               if (out_ready) begin
                  r_state    <= ST_IDLE;
                  r_outValid <= 1'b0;
               end
            end

            default: begin
               r_state    <= ST_IDLE;
               r_outValid <= 1'b0;
            end
         endcase
      end
   end

   // Output mapping. eq_all is qualified by out_valid, so it only reports
   // a uniform frame while a result is actually being presented.
   assign in_ready  = w_inReady;
   assign out_valid = r_outValid;
   assign min_val   = r_min;
   assign max_val   = r_max;
   assign count     = r_count;
   assign ovf       = r_ovf;
   assign eq_all    = r_outValid & w_minMaxEqual;
`ifdef MINMAX_INDEX_EN
   assign min_idx   = r_minIdx;
   assign max_idx   = r_maxIdx;
`endif

endmodule

// File: tb/tb_minmax_tracker.sv
// ---------------------------------------------------------------------------
// tb_minmax_tracker
//
// Directed self-checking bench for minmax_tracker. dut0 uses N=8, CNT_W=8.
// dut1 uses CNT_W=3 so that counter saturation is reachable with short
// frames. Index outputs are checked only when MINMAX_INDEX_EN is defined.
// ---------------------------------------------------------------------------
module tb_minmax_tracker;

   logic       clk;
   logic       rst_n;

   // dut0 (CNT_W = 8)
   logic       inValid0, inReady0, inLast0, outValid0, outReady0;
   logic [7:0] inData0, minVal0, maxVal0, count0;
   logic       ovf0, eqAll0;
   // dut1 (CNT_W = 3)
   logic       inValid1, inReady1, inLast1, outValid1, outReady1;
   logic [7:0] inData1, minVal1, maxVal1;
   logic [2:0] count1;
   logic       ovf1, eqAll1;
`ifdef MINMAX_INDEX_EN
   logic [7:0] minIdx0, maxIdx0;
   logic [2:0] minIdx1, maxIdx1;
`endif

   int checkCount;
   int errorCount;

   minmax_tracker #(.N(8), .CNT_W(8)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(inValid0), .in_ready(inReady0), .in_data(inData0), .in_last(inLast0),
      .out_valid(outValid0), .out_ready(outReady0),
      .min_val(minVal0), .max_val(maxVal0), .count(count0), .ovf(ovf0), .eq_all(eqAll0)
`ifdef MINMAX_INDEX_EN
      , .min_idx(minIdx0), .max_idx(maxIdx0)
`endif
   );

   minmax_tracker #(.N(8), .CNT_W(3)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(inValid1), .in_ready(inReady1), .in_data(inData1), .in_last(inLast1),
      .out_valid(outValid1), .out_ready(outReady1),
      .min_val(minVal1), .max_val(maxVal1), .count(count1), .ovf(ovf1), .eq_all(eqAll1)
`ifdef MINMAX_INDEX_EN
      , .min_idx(minIdx1), .max_idx(maxIdx1)
`endif
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advance one clock and settle just after the edge
   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   // Present one sample to the selected DUT and hold it until accepted.
   // The wait for in_ready is bounded; an expired bound is a failure.
   task automatic applyStimulus(input bit sel, input logic [7:0] data, input bit last);
      int waitCycles;
      waitCycles = 0;
      if (sel == 1'b0) begin
         inValid0 = 1'b1; inData0 = data; inLast0 = last;
         while (!inReady0 && waitCycles < 20) begin
            stepClock();
            waitCycles++;
         end
      end else begin
         inValid1 = 1'b1; inData1 = data; inLast1 = last;
         while (!inReady1 && waitCycles < 20) begin
            stepClock();
            waitCycles++;
         end
      end
      if (waitCycles >= 20) checkOutput("inReadyTimeout", 32'(waitCycles), 32'd0);
      stepClock();
      inValid0 = 1'b0; inLast0 = 1'b0;
      inValid1 = 1'b0; inLast1 = 1'b0;
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      rst_n     = 1'b0;
      inValid0  = 1'b0; inData0 = 8'h00; inLast0 = 1'b0; outReady0 = 1'b0;
      inValid1  = 1'b0; inData1 = 8'h00; inLast1 = 1'b0; outReady1 = 1'b1;

      // Reset state
      #2;
      checkOutput("rstInReady",  32'(inReady0),  32'd1);
      checkOutput("rstOutValid", 32'(outValid0), 32'd0);
      checkOutput("rstMin",      32'(minVal0),   32'd0);
      checkOutput("rstMax",      32'(maxVal0),   32'd0);
      checkOutput("rstCount",    32'(count0),    32'd0);
      checkOutput("rstOvf",      32'(ovf0),      32'd0);
      checkOutput("rstEqAll",    32'(eqAll0),    32'd0);
`ifdef MINMAX_INDEX_EN
      checkOutput("rstMinIdx",   32'(minIdx0),   32'd0);
      checkOutput("rstMaxIdx",   32'(maxIdx0),   32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      stepClock();

      // in_last without in_valid does nothing
      inLast0 = 1'b1;
      stepClock();
      inLast0 = 1'b0;
      checkOutput("lastNoValidOutValid", 32'(outValid0), 32'd0);
      checkOutput("lastNoValidCount",    32'(count0),    32'd0);

      // Frame 5,3,9,3,9 with ties on both extremes
      applyStimulus(1'b0, 8'd5, 1'b0);
      applyStimulus(1'b0, 8'd3, 1'b0);
      applyStimulus(1'b0, 8'd9, 1'b0);
      applyStimulus(1'b0, 8'd3, 1'b0);
      checkOutput("f1PreLastOutValid", 32'(outValid0), 32'd0);
      checkOutput("f1PreLastCount",    32'(count0),    32'd4);
      applyStimulus(1'b0, 8'd9, 1'b1);
      checkOutput("f1OutValid", 32'(outValid0), 32'd1);
      checkOutput("f1InReady",  32'(inReady0),  32'd0);
      checkOutput("f1Min",      32'(minVal0),   32'd3);
      checkOutput("f1Max",      32'(maxVal0),   32'd9);
      checkOutput("f1Count",    32'(count0),    32'd5);
      checkOutput("f1EqAll",    32'(eqAll0),    32'd0);
      checkOutput("f1Ovf",      32'(ovf0),      32'd0);
`ifdef MINMAX_INDEX_EN
      checkOutput("f1MinIdx",   32'(minIdx0),   32'd1);
      checkOutput("f1MaxIdx",   32'(maxIdx0),   32'd2);
`endif
      outReady0 = 1'b1;
      stepClock();
      checkOutput("f1DoneOutValid", 32'(outValid0), 32'd0);
      checkOutput("f1DoneInReady",  32'(inReady0),  32'd1);
      checkOutput("f1DoneMinKept",  32'(minVal0),   32'd3);

      // Single-sample frame with out_ready held high
      applyStimulus(1'b0, 8'hAA, 1'b1);
      checkOutput("singleOutValid", 32'(outValid0), 32'd1);
      checkOutput("singleMin",      32'(minVal0),   32'hAA);
      checkOutput("singleMax",      32'(maxVal0),   32'hAA);
      checkOutput("singleCount",    32'(count0),    32'd1);
      checkOutput("singleEqAll",    32'(eqAll0),    32'd1);
      stepClock();
      checkOutput("singleHoldOneCycle", 32'(outValid0), 32'd0);
      checkOutput("singleInReadyBack",  32'(inReady0),  32'd1);
      checkOutput("singleEqAllDrop",    32'(eqAll0),    32'd0);

      // Back-pressure in HOLD with a sample waiting
      outReady0 = 1'b0;
      applyStimulus(1'b0, 8'd1, 1'b0);
      applyStimulus(1'b0, 8'd2, 1'b1);
      inValid0 = 1'b1; inData0 = 8'h42; inLast0 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         stepClock();
         checkOutput($sformatf("bpInReady%0d", i),  32'(inReady0),  32'd0);
         checkOutput($sformatf("bpOutValid%0d", i), 32'(outValid0), 32'd1);
         checkOutput($sformatf("bpCount%0d", i),    32'(count0),    32'd2);
         checkOutput($sformatf("bpMax%0d", i),      32'(maxVal0),   32'd2);
      end
      outReady0 = 1'b1;
      stepClock();
      checkOutput("bpReleaseOutValid", 32'(outValid0), 32'd0);
      checkOutput("bpReleaseInReady",  32'(inReady0),  32'd1);
      checkOutput("bpReleaseCount",    32'(count0),    32'd2);
      outReady0 = 1'b0;
      stepClock();
      inValid0 = 1'b0; inLast0 = 1'b0;
      checkOutput("bpPendingOutValid", 32'(outValid0), 32'd1);
      checkOutput("bpPendingMin",      32'(minVal0),   32'h42);
      checkOutput("bpPendingCount",    32'(count0),    32'd1);
      outReady0 = 1'b1;
      stepClock();

      // Asynchronous reset mid-frame
      applyStimulus(1'b0, 8'd10, 1'b0);
      applyStimulus(1'b0, 8'd20, 1'b0);
      applyStimulus(1'b0, 8'd30, 1'b0);
      checkOutput("preRstCount", 32'(count0), 32'd3);
      rst_n = 1'b0;
      #1;
      checkOutput("midRstCount",    32'(count0),    32'd0);
      checkOutput("midRstMin",      32'(minVal0),   32'd0);
      checkOutput("midRstMax",      32'(maxVal0),   32'd0);
      checkOutput("midRstOutValid", 32'(outValid0), 32'd0);
      checkOutput("midRstInReady",  32'(inReady0),  32'd1);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      stepClock();
      applyStimulus(1'b0, 8'd7, 1'b0);
      applyStimulus(1'b0, 8'd2, 1'b1);
      checkOutput("postRstMin",   32'(minVal0), 32'd2);
      checkOutput("postRstMax",   32'(maxVal0), 32'd7);
      checkOutput("postRstCount", 32'(count0),  32'd2);
      stepClock();

      // Unsigned ordering with both extremes present
      applyStimulus(1'b0, 8'h80, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      applyStimulus(1'b0, 8'hFF, 1'b0);
      applyStimulus(1'b0, 8'h7F, 1'b1);
      checkOutput("unsMin",   32'(minVal0), 32'h00);
      checkOutput("unsMax",   32'(maxVal0), 32'hFF);
      checkOutput("unsCount", 32'(count0),  32'd4);
`ifdef MINMAX_INDEX_EN
      checkOutput("unsMinIdx", 32'(minIdx0), 32'd1);
      checkOutput("unsMaxIdx", 32'(maxIdx0), 32'd2);
`endif
      stepClock();

      // Saturation on the CNT_W=3 instance: nine 0x10 then 0xFF last
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, 8'h10, 1'b0);
      applyStimulus(1'b1, 8'hFF, 1'b1);
      checkOutput("satOutValid", 32'(outValid1), 32'd1);
      checkOutput("satCount",    32'(count1),    32'd7);
      checkOutput("satOvf",      32'(ovf1),      32'd1);
      checkOutput("satMax",      32'(maxVal1),   32'hFF);
      checkOutput("satMin",      32'(minVal1),   32'h10);
`ifdef MINMAX_INDEX_EN
      checkOutput("satMaxIdx",   32'(maxIdx1),   32'd7);
      checkOutput("satMinIdx",   32'(minIdx1),   32'd0);
`endif
      stepClock();

      // Exactly seven samples: count reaches all-ones without ovf,
      // and ovf from the previous frame is cleared
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'd3, 1'b0);
      applyStimulus(1'b1, 8'd1, 1'b1);
      checkOutput("fullCount", 32'(count1),  32'd7);
      checkOutput("fullOvf",   32'(ovf1),    32'd0);
      checkOutput("fullMin",   32'(minVal1), 32'd1);
      checkOutput("fullMax",   32'(maxVal1), 32'd3);
`ifdef MINMAX_INDEX_EN
      checkOutput("fullMinIdx", 32'(minIdx1), 32'd6);
      checkOutput("fullMaxIdx", 32'(maxIdx1), 32'd0);
`endif
      stepClock();

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
